vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock and drives the VGA pins. It is the producer side of the hCount/vCount/bright interface consumed by the game and pipe renderers. It emits internal pixel counters and blanking, registers the renderer's `rgb_in` together with the sync signals at the pins, and provides a per-frame tick and frame counter for game-state updates.

## Interface
- `CLK_DIV`, 4: clk cycles per pixel; must be ≥1.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: hsync pulse width, starting at hCount=0.
- `H_ACT_START`, 144: first visible column.
- `H_ACT_END`, 784: first column past the visible area.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vsync pulse width, starting at vCount=0.
- `V_ACT_START`, 35: first visible line.
- `V_ACT_END`, 515: first line past the visible area.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rgb_in` in 12: pixel colour {R,G,B} from the renderer; a combinational function of hCount/vCount.
- `hCount` out 10: horizontal pixel counter, 0..H_TOTAL-1.
- `vCount` out 10: vertical line counter, 0..V_TOTAL-1.
- `bright` out 1: high inside the visible area.
- `hSync` out 1: active-low hsync, combinational decode of hCount, aligned with the counters.
- `vSync` out 1: active-low vsync, combinational decode of vCount, aligned with the counters.
- `pix_en` out 1: one-clk strobe every CLK_DIV clks; the counters advance on it.
- `vga_r` out 4: registered pin colour, red.
- `vga_g` out 4: registered pin colour, green.
- `vga_b` out 4: registered pin colour, blue.
- `vga_hsync` out 1: registered pin sync, horizontal.
- `vga_vsync` out 1: registered pin sync, vertical.
- `frame_tick` out 1: one-clk pulse at the start of vertical blanking.
- `frame_cnt` out 8: frame counter, incremented on each frame_tick, wraps 255→0.

## Operation
- **Divider.**
  - `div` counts 0..CLK_DIV-1 on every clk and wraps.
  - `pix_en = (div == CLK_DIV-1)`.
  - With CLK_DIV=1, pix_en is constantly 1.
- **Horizontal counter.** On a clk edge with pix_en=1, hCount increments. At H_TOTAL-1 it wraps to 0 and vCount advances.
- **Vertical counter.** vCount increments on each line wrap. At V_TOTAL-1 (with hCount=H_TOTAL-1) it wraps to 0.
- **Decodes** (combinational from the registered counters):
  - hSync = ~(hCount < H_SYNC).
  - vSync = ~(vCount < V_SYNC).
  - bright = (H_ACT_START ≤ hCount < H_ACT_END) && (V_ACT_START ≤ vCount < V_ACT_END).
- **Pin stage.** Registered, updates only on pix_en:
  - {vga_r,vga_g,vga_b} <= bright ? rgb_in : 12'h000.
  - vga_hsync <= hSync.
  - vga_vsync <= vSync.
  - Outside bright the pins are black regardless of rgb_in.
- **Frame tick.**
  - Register: frame_tick <= pix_en && hCount==H_TOTAL-1 && vCount==V_ACT_END-1.
  - It is therefore high for exactly the one clk after the counters move to (0, V_ACT_END).
  - frame_cnt increments in the same cycle frame_tick is high; the new value is visible the clk after.
- **Width rules.**
  - All comparisons are unsigned 10-bit.
  - The counters never exceed their TOTAL-1; no other overflow paths exist.
- **Reset (async, any time, including mid-line or mid-frame).** All state clears immediately:
  - div=0, hCount=0, vCount=0, vga_rgb=0, vga_hsync=1, vga_vsync=1, frame_tick=0, frame_cnt=0.
  - During reset: pix_en=(CLK_DIV==1), bright=0, hSync=0, vSync=0 (decodes of zero counters).
  - After release, timing restarts from (0,0) with a full CLK_DIV clks before the first advance.

## Timing
- Pixel period CLK_DIV clks. Line = 800 pixels = 3200 clks. Frame = 525 lines = 1,680,000 clks at the defaults.
- Counter latency: the count changes on the clk edge where pix_en=1. First advance is at the CLK_DIV-th edge after rst falls.
- Pin latency: exactly one pixel period. The pins show the colour/sync for counter value N while the counters hold N+1.
  - The renderer needs no compensation; sync and colour are mutually aligned.
- Visible window (defaults): hCount 144..783, vCount 35..514. hsync low for hCount 0..95; vsync low for vCount 0..1.
- frame_tick spacing: exactly V_TOTAL*H_TOTAL*CLK_DIV clks. Always one clk wide, including when CLK_DIV=1.

## Test plan
- **Reset.** Assert rst mid-frame at (400,200) → same cycle: hCount=0, vCount=0, vga_hsync=1, vga_vsync=1, vga_rgb=0, frame_cnt=0. After release, first hCount=1 on the 4th clk edge.
- **Divider.** Run 40 clks → pix_en high at clks 4, 8, …, 40 only. With CLK_DIV=1 → pix_en constantly high and hCount increments every clk.
- **Line/frame wrap.**
  - hCount 799→0 with vCount 10→11.
  - (799,524)→(0,0).
  - hSync low exactly for 0..95; vSync low for lines 0..1.
- **bright boundaries.**
  - Low at (143,35), (784,35), (144,34), (144,515).
  - High at (144,35) and (783,514).
- **Pin pipeline.** rgb_in=12'hF00 held → vga_r=F, vga_g=0, vga_b=0 one pixel after bright rises at (144,35). Pins return to 0 one pixel after (784,y). vga_hsync falls one pixel after hCount=0.
- **Frame tick.** Run 3 frames → frame_tick pulses 1 clk after reaching (0,515), spaced 1,680,000 clks apart, frame_cnt 0→1→2→3. Preload frame_cnt=255 → next tick gives 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Produces 640x480@60 Hz VGA raster timing from the system clock. A
//   clock divider creates the pixel strobe. The horizontal and vertical
//   counters advance on that strobe. Sync and blanking are decoded
//   combinationally from the counters. The renderer colour and the syncs
//   are registered together at the pins, so they stay aligned. A
//   per-frame tick and a frame counter pace game-state updates.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rgb_in     in   {R,G,B} from the renderer, a function of hCount/vCount
//   hCount     out  pixel column, 0..H_TOTAL-1
//   vCount     out  line, 0..V_TOTAL-1
//   bright     out  high inside the visible window
//   hSync      out  active-low hsync decode, aligned with the counters
//   vSync      out  active-low vsync decode, aligned with the counters
//   pix_en     out  one-clk strobe every CLK_DIV clks
//   vga_r/g/b  out  registered pin colour, forced black outside bright
//   vga_hsync  out  registered pin hsync
//   vga_vsync  out  registered pin vsync
//   frame_tick out  one-clk pulse at the start of vertical blanking
//   frame_cnt  out  frame counter, wraps 255 -> 0
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        pix_en,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_tick,
  output logic [7:0]  frame_cnt
);

  // With CLK_DIV == 1 the divider collapses to a constant 0 register, so
  // pix_en is permanently high.
  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_AS    = 10'(H_ACT_START);
  localparam logic [9:0] H_AE    = 10'(H_ACT_END);
  localparam logic [9:0] V_AS    = 10'(V_ACT_START);
  localparam logic [9:0] V_AE    = 10'(V_ACT_END);
  localparam logic [9:0] V_BLANK_LAST = 10'(V_ACT_END - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_pin_q, hs_pin_d;
  logic             vs_pin_q, vs_pin_d;
  logic             tick_q, tick_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             pix_en_w;
  logic             h_sync_w, v_sync_w, bright_w;
  logic             line_end;

  always_comb begin
    pix_en_w = (div_q == DIV_LAST);
    line_end = (h_q == H_LAST);

    h_sync_w = ~(h_q < H_SYNC_C);
    v_sync_w = ~(v_q < V_SYNC_C);
    bright_w = (h_q >= H_AS) && (h_q < H_AE) && (v_q >= V_AS) && (v_q < V_AE);

    div_d    = pix_en_w ? '0 : div_q + DIV_W'(1);

    h_d      = h_q;
    v_d      = v_q;
    rgb_d    = rgb_q;
    hs_pin_d = hs_pin_q;
    vs_pin_d = vs_pin_q;
    if (pix_en_w) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Pins capture the decode of the pixel being left, so colour and
      // sync stay mutually aligned one pixel behind the counters.
      rgb_d    = bright_w ? rgb_in : 12'h000;
      hs_pin_d = h_sync_w;
      vs_pin_d = v_sync_w;
    end

    tick_d = pix_en_w && line_end && (v_q == V_BLANK_LAST);
    // The counter follows the registered tick, so its new value appears
    // the clk after the pulse.
    cnt_d  = cnt_q + {7'd0, tick_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      rgb_q    <= '0;
      hs_pin_q <= 1'b1;
      vs_pin_q <= 1'b1;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      rgb_q    <= rgb_d;
      hs_pin_q <= hs_pin_d;
      vs_pin_q <= vs_pin_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = bright_w;
  assign hSync      = h_sync_w;
  assign vSync      = v_sync_w;
  assign pix_en     = pix_en_w;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign vga_hsync  = hs_pin_q;
  assign vga_vsync  = vs_pin_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share one clock:
//   A - small raster, CLK_DIV=3, random asynchronous resets
//   B - tiny raster, CLK_DIV=1, runs past 256 frames for the counter wrap
//   C - default 640x480 timing for the first lines
// All outputs are compared every cycle against a closed-form model. The
// model derives the expected state from the number of clk edges since the
// last reset release.
module tb_vga_timing_gen;

  typedef struct {
    int d; int h; int hs; int has; int hae; int v; int vs; int vas; int vae;
  } geom_t;

  localparam int A_D = 3, A_H = 40, A_HS = 6, A_HAS = 10, A_HAE = 36;
  localparam int A_V = 24, A_VS = 2, A_VAS = 4, A_VAE = 21;
  localparam int B_D = 1, B_H = 16, B_HS = 3, B_HAS = 5, B_HAE = 14;
  localparam int B_V = 10, B_VS = 1, B_VAS = 2, B_VAE = 9;
  localparam int C_D = 4, C_H = 800, C_HS = 96, C_HAS = 144, C_HAE = 784;
  localparam int C_V = 525, C_VS = 2, C_VAS = 35, C_VAE = 515;
  localparam int NCYC = 42000;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] rgb_in;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic br_a, hs_a, vs_a, pe_a, vhs_a, vvs_a, tk_a;
  logic br_b, hs_b, vs_b, pe_b, vhs_b, vvs_b, tk_b;
  logic br_c, hs_c, vs_c, pe_c, vhs_c, vvs_c, tk_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic [7:0] fc_a, fc_b, fc_c;

  vga_timing_gen #(.CLK_DIV(A_D), .H_TOTAL(A_H), .H_SYNC(A_HS), .H_ACT_START(A_HAS),
    .H_ACT_END(A_HAE), .V_TOTAL(A_V), .V_SYNC(A_VS), .V_ACT_START(A_VAS),
    .V_ACT_END(A_VAE)) u_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_in), .hCount(hc_a), .vCount(vc_a),
    .bright(br_a), .hSync(hs_a), .vSync(vs_a), .pix_en(pe_a), .vga_r(r_a),
    .vga_g(g_a), .vga_b(b_a), .vga_hsync(vhs_a), .vga_vsync(vvs_a),
    .frame_tick(tk_a), .frame_cnt(fc_a));

  vga_timing_gen #(.CLK_DIV(B_D), .H_TOTAL(B_H), .H_SYNC(B_HS), .H_ACT_START(B_HAS),
    .H_ACT_END(B_HAE), .V_TOTAL(B_V), .V_SYNC(B_VS), .V_ACT_START(B_VAS),
    .V_ACT_END(B_VAE)) u_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_in), .hCount(hc_b), .vCount(vc_b),
    .bright(br_b), .hSync(hs_b), .vSync(vs_b), .pix_en(pe_b), .vga_r(r_b),
    .vga_g(g_b), .vga_b(b_b), .vga_hsync(vhs_b), .vga_vsync(vvs_b),
    .frame_tick(tk_b), .frame_cnt(fc_b));

  vga_timing_gen u_c (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_in), .hCount(hc_c), .vCount(vc_c),
    .bright(br_c), .hSync(hs_c), .vSync(vs_c), .pix_en(pe_c), .vga_r(r_c),
    .vga_g(g_c), .vga_b(b_c), .vga_hsync(vhs_c), .vga_vsync(vvs_c),
    .frame_tick(tk_c), .frame_cnt(fc_c));

  // Observation vector: {h, v, bright, hSync, vSync, pix_en, rgb, pin hs,
  // pin vs, frame_tick, frame_cnt}
  wire [46:0] obs_a = {hc_a, vc_a, br_a, hs_a, vs_a, pe_a, r_a, g_a, b_a, vhs_a, vvs_a, tk_a, fc_a};
  wire [46:0] obs_b = {hc_b, vc_b, br_b, hs_b, vs_b, pe_b, r_b, g_b, b_b, vhs_b, vvs_b, tk_b, fc_b};
  wire [46:0] obs_c = {hc_c, vc_c, br_c, hs_c, vs_c, pe_c, r_c, g_c, b_c, vhs_c, vvs_c, tk_c, fc_c};

  task automatic chk(input string tag, input logic [46:0] got, input logic [46:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic in_vis(input geom_t g, input int q);
    int h, v;
    h = q % g.h;
    v = (q / g.h) % g.v;
    return (h >= g.has) && (h < g.hae) && (v >= g.vas) && (v < g.vae);
  endfunction

  // Expected outputs after t clk edges since reset release. cap is the
  // colour the bench presented at the most recent pixel strobe, masked by
  // visibility.
  function automatic logic [46:0] model(input geom_t g, input int t, input logic [11:0] cap);
    int p, h, v, q, f0, fp;
    logic br, hs, vs, pe, vhs, vvs, tick;
    logic [11:0] pin;
    logic [7:0]  cnt;
    p  = t / g.d;
    h  = p % g.h;
    v  = (p / g.h) % g.v;
    pe = (t % g.d) == g.d - 1;
    br = in_vis(g, p);
    hs = !(h < g.hs);
    vs = !(v < g.vs);
    pin = 12'h000; vhs = 1'b1; vvs = 1'b1; tick = 1'b0;
    if (p > 0) begin
      q    = p - 1;
      pin  = cap;
      vhs  = !((q % g.h) < g.hs);
      vvs  = !(((q / g.h) % g.v) < g.vs);
      tick = (t % g.d == 0) && (q % g.h == g.h - 1) && ((q / g.h) % g.v == g.vae - 1);
    end
    // Ticks land on edges (k*H*V + VAE*H)*D; the count shows them one edge later.
    f0  = g.vae * g.h * g.d;
    fp  = g.h * g.v * g.d;
    cnt = (t - 1 >= f0) ? 8'((t - 1 - f0) / fp + 1) : 8'h00;
    return {10'(h), 10'(v), br, hs, vs, pe, pin, vhs, vvs, tick, cnt};
  endfunction

  geom_t ga, gb, gc;
  int t_a, t_b, t_c;
  int hold_a, hold_b;
  logic [11:0] cap_a, cap_b, cap_c;

  initial begin
    ga = '{A_D, A_H, A_HS, A_HAS, A_HAE, A_V, A_VS, A_VAS, A_VAE};
    gb = '{B_D, B_H, B_HS, B_HAS, B_HAE, B_V, B_VS, B_VAS, B_VAE};
    gc = '{C_D, C_H, C_HS, C_HAS, C_HAE, C_V, C_VS, C_VAS, C_VAE};
    t_a = 0; t_b = 0; t_c = 0; hold_a = 0; hold_b = 0;
    cap_a = '0; cap_b = '0; cap_c = '0;
    rst_a = 1'b1; rst_b = 1'b1; rgb_in = 12'hF00;

    repeat (2) @(negedge clk);
    chk("A_reset", obs_a, model(ga, 0, cap_a));
    chk("B_reset", obs_b, model(gb, 0, cap_b));
    chk("C_reset", obs_c, model(gc, 0, cap_c));
    rst_a = 1'b0; rst_b = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (!rst_a) begin
        t_a++;
        if (t_a % ga.d == 0) cap_a = in_vis(ga, t_a / ga.d - 1) ? rgb_in : 12'h000;
      end
      if (!rst_b) begin
        t_b++;
        if (t_b % gb.d == 0) cap_b = in_vis(gb, t_b / gb.d - 1) ? rgb_in : 12'h000;
        t_c++;
        if (t_c % gc.d == 0) cap_c = in_vis(gc, t_c / gc.d - 1) ? rgb_in : 12'h000;
      end

      @(negedge clk);
      chk($sformatf("A_cyc%0d", cyc), obs_a, model(ga, t_a, cap_a));
      chk($sformatf("B_cyc%0d", cyc), obs_b, model(gb, t_b, cap_b));
      chk($sformatf("C_cyc%0d", cyc), obs_c, model(gc, t_c, cap_c));

      if (rst_a) begin
        if (hold_a == 0) rst_a = 1'b0;
        else hold_a--;
      end else if (cyc == 5000 || $urandom_range(0, 2499) == 0) begin
        rst_a = 1'b1; t_a = 0; hold_a = $urandom_range(0, 3);
        #1 chk("A_async_rst", obs_a, model(ga, 0, cap_a));
      end

      if (rst_b) begin
        if (hold_b == 0) rst_b = 1'b0;
        else hold_b--;
      end else if (cyc == NCYC - 200) begin
        rst_b = 1'b1; t_b = 0; t_c = 0; hold_b = 2;
        #1;
        chk("B_async_rst", obs_b, model(gb, 0, cap_b));
        chk("C_async_rst", obs_c, model(gc, 0, cap_c));
      end

      // Mostly random colour, with stretches of solid red.
      rgb_in = ($urandom_range(0, 3) == 0) ? 12'hF00 : 12'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
